// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the score controller and its BCD converter.
//   SCORE_W / BCD_W     : width of the binary score and of the packed digits
//   DEFAULT_MAX_SCORE   : default saturation ceiling (four decimal digits)
//   state_t             : controller FSM states
//   bcd_digit_t         : one BCD nibble
//   sat_update()        : saturating add/subtract on the binary score
// -----------------------------------------------------------------------------
package score_pkg;

   localparam int SCORE_W           = 16;
   localparam int BCD_W             = 16;
   localparam int DEFAULT_MAX_SCORE = 9999;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   typedef logic [3:0] bcd_digit_t;

   // One extra bit of headroom lets the add detect overflow past the ceiling
   // and the subtract detect a borrow below zero.
   function automatic logic [SCORE_W-1:0] sat_update(
      input logic [SCORE_W-1:0] cur,
      input logic [SCORE_W:0]   amt,
      input logic               is_sub,
      input logic [SCORE_W-1:0] max_val
   );
      logic [SCORE_W:0] sum;
      logic [SCORE_W:0] diff;
      sum  = {1'b0, cur} + amt;
      diff = {1'b0, cur} - amt;
      if (is_sub)
         sat_update = diff[SCORE_W] ? '0 : diff[SCORE_W-1:0];
      else
         sat_update = (sum > {1'b0, max_val}) ? max_val : sum[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one bit per step.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture bin and clear the BCD accumulator
//   bin        : binary value to convert (sampled on load)
//   step       : perform one add-3/shift step
//   digits     : four BCD digits, valid after 16 steps
// A 20-bit shift/add register holds five digits so any 16-bit input converts
// without overflow; a non-zero fifth digit (only possible if the ceiling is
// raised above 9999) pins the four displayed digits at 9999.
// -----------------------------------------------------------------------------
module bin2bcd_seq
   import score_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [SCORE_W-1:0] bin,
   input  logic               step,
   output logic [BCD_W-1:0]   digits
);

   localparam int NIB  = 5;
   localparam int SR_W = 4 * NIB;

   logic [SCORE_W-1:0] bin_reg;
   logic [SR_W-1:0]    sr_reg;
   logic [SR_W-1:0]    sr_adj;

   genvar gi;
   generate
      for (gi = 0; gi < NIB; gi++) begin : g_adj
         bcd_digit_t nib;
         assign nib = sr_reg[4*gi +: 4];
         assign sr_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_reg <= '0;
         sr_reg  <= '0;
      end else if (load) begin
         bin_reg <= bin;
         sr_reg  <= '0;
      end else if (step) begin
         sr_reg  <= {sr_adj[SR_W-2:0], bin_reg[SCORE_W-1]};
         bin_reg <= {bin_reg[SCORE_W-2:0], 1'b0};
      end
   end

   assign digits = (sr_reg[SR_W-1:BCD_W] != 4'd0) ? 16'h9999 : sr_reg[BCD_W-1:0];

endmodule

// File: rtl/score_ctrl.sv
// -----------------------------------------------------------------------------
// score_ctrl
// Round-robin arbitrated, saturating score register with registered BCD digits.
//   clk, reset  : clock and synchronous active-high reset
//   clear       : new-game clear pulse (same effect as reset)
//   req         : per-requester request level, held until acked
//   amount      : per-requester magnitude
//   sub         : per-requester direction, 1 = subtract
//   ack         : one-hot one-cycle grant pulse
//   score       : binary score, 0..MAX_SCORE
//   bcd         : thousands/hundreds/tens/ones digits
//   bcd_update  : one-cycle pulse when bcd changes
//   busy        : high while an update/conversion is in flight
// One update is applied per pass IDLE -> CONV (16 steps) -> DONE -> IDLE.
// -----------------------------------------------------------------------------
module score_ctrl
   import score_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int AMT_W     = 8,
   parameter int MAX_SCORE = DEFAULT_MAX_SCORE
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0][AMT_W-1:0] amount,
   input  logic [NUM_REQ-1:0]            sub,
   output logic [NUM_REQ-1:0]            ack,
   output logic [SCORE_W-1:0]            score,
   output logic [BCD_W-1:0]              bcd,
   output logic                          bcd_update,
   output logic                          busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW    = PTR_W + 1;
   localparam int AW    = SCORE_W + 1;
   localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

   state_t             state_reg;
   logic [PTR_W-1:0]   ptr_reg;
   logic [3:0]         cnt_reg;
   logic [NUM_REQ-1:0] ack_reg;
   logic [SCORE_W-1:0] score_reg;
   logic [BCD_W-1:0]   bcd_reg;
   logic               bcd_update_reg;
   logic               busy_reg;

   logic               grant_valid;
   logic [PTR_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant_onehot;
   logic [CW-1:0]      cand_w;
   logic [PTR_W-1:0]   cand;
   logic [SCORE_W-1:0] score_next;
   logic [PTR_W-1:0]   ptr_next;
   logic [BCD_W-1:0]   conv_digits;
   logic               conv_load;
   logic               conv_step;

   // First requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand_w      = '0;
      cand        = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_w = {1'b0, ptr_reg} + CW'(i);
         if (cand_w >= CW'(NUM_REQ))
            cand_w = cand_w - CW'(NUM_REQ);
         cand = cand_w[PTR_W-1:0];
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
         assign grant_onehot[gi] = grant_valid && (grant_idx == PTR_W'(gi));
      end
   endgenerate

   assign score_next = sat_update(score_reg, AW'(amount[grant_idx]), sub[grant_idx], MAX_VAL);
   assign ptr_next   = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

   // A clear in the grant cycle wins, so the converter must not load either.
   assign conv_load = (state_reg == IDLE) && grant_valid && !clear;
   assign conv_step = (state_reg == CONV) && !clear;

   bin2bcd_seq u_bin2bcd (
      .clk    (clk),
      .reset  (reset),
      .load   (conv_load),
      .bin    (score_next),
      .step   (conv_step),
      .digits (conv_digits)
   );

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_reg      <= IDLE;
         ptr_reg        <= '0;
         cnt_reg        <= '0;
         ack_reg        <= '0;
         score_reg      <= '0;
         bcd_reg        <= '0;
         bcd_update_reg <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         ack_reg        <= '0;
         bcd_update_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (grant_valid) begin
                  ack_reg   <= grant_onehot;
                  score_reg <= score_next;
                  ptr_reg   <= ptr_next;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= CONV;
               end
            end
            CONV: begin
               cnt_reg <= cnt_reg + 4'd1;
               if (cnt_reg == 4'd15)
                  state_reg <= DONE;
            end
            DONE: begin
               bcd_reg        <= conv_digits;
               bcd_update_reg <= 1'b1;
               busy_reg       <= 1'b0;
               state_reg      <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign ack        = ack_reg;
   assign score      = score_reg;
   assign bcd        = bcd_reg;
   assign bcd_update = bcd_update_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_score_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_ctrl
// Directed bench for score_ctrl: reset state, add/subtract with saturation,
// 17-cycle digit latency, round-robin order and spacing, clear behaviour.
// -----------------------------------------------------------------------------
module tb_score_ctrl;

   logic            clk = 1'b0;
   logic            reset;
   logic            clear;
   logic [3:0]      req;
   logic [3:0][7:0] amount;
   logic [3:0]      sub;
   logic [3:0]      ack;
   logic [15:0]     score;
   logic [15:0]     bcd;
   logic            bcd_update;
   logic            busy;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] prev_bcd;

   always #5 clk = ~clk;

   score_ctrl #(.NUM_REQ(4), .AMT_W(8), .MAX_SCORE(9999)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .req        (req),
      .amount     (amount),
      .sub        (sub),
      .ack        (ack),
      .score      (score),
      .bcd        (bcd),
      .bcd_update (bcd_update),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Waits (bounded) for a non-zero ack; a timeout returns a = 0.
   task automatic wait_ack(output int cyc, output logic [3:0] a);
      cyc = 0;
      a   = 4'b0;
      while (a == 4'b0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         a = ack;
      end
   endtask

   // Called in the cycle after the grant edge; n ends as the grant-to-digit latency.
   task automatic wait_update(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) check("ack_pulse", 32'(ack), 32'h0);
         if (n == 8) check("bcd_hold", 32'(bcd), 32'(prev_bcd));
      end while (!bcd_update && n < 40);
   endtask

   task automatic apply(input int idx, input int amt, input bit s,
                        input int exp_score, input logic [15:0] exp_bcd);
      int         cyc;
      int         lat;
      logic [3:0] a;
      req[idx]    = 1'b1;
      amount[idx] = 8'(amt);
      sub[idx]    = s;
      wait_ack(cyc, a);
      req[idx] = 1'b0;
      check("ack", 32'(a), 32'(1 << idx));
      check("score", 32'(score), 32'(exp_score));
      check("busy_hi", 32'(busy), 32'h1);
      wait_update(lat);
      check("latency", lat, 17);
      check("bcd", 32'(bcd), 32'(exp_bcd));
      check("busy_lo", 32'(busy), 32'h0);
      prev_bcd = exp_bcd;
      $display("apply req%0d amt=%0d sub=%0b score=%0d bcd=%h", idx, amt, s, score, bcd);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_score", 32'(score), 32'h0);
      check("clr_bcd", 32'(bcd), 32'h0);
      check("clr_busy", 32'(busy), 32'h0);
      prev_bcd = 16'h0;
      $display("clear score=%0d bcd=%h busy=%0b", score, bcd, busy);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cyc;
      int         lat;
      int         upd;
      int         g;
      int         exp_sc;
      logic [3:0] a;

      reset    = 1'b1;
      clear    = 1'b0;
      req      = 4'b0;
      sub      = 4'b0;
      amount   = '0;
      prev_bcd = 16'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_score", 32'(score), 32'h0);
      check("rst_bcd", 32'(bcd), 32'h0);
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_upd", 32'(bcd_update), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      $display("reset score=%0d bcd=%h busy=%0b", score, bcd, busy);

      // First update: 0 + 5.
      apply(0, 5, 1'b0, 5, 16'h0005);

      // Climb to the ceiling: 5 + 255*k, saturating at 9999 on the 40th add.
      for (int k = 1; k <= 40; k++) begin
         exp_sc = (5 + 255 * k > 9999) ? 9999 : 5 + 255 * k;
         apply(1, 255, 1'b0, exp_sc, to_bcd(exp_sc));
      end
      apply(1, 9, 1'b1, 9990, 16'h9990);
      apply(1, 20, 1'b0, 9999, 16'h9999);
      apply(1, 1, 1'b0, 9999, 16'h9999);

      // Subtract floors at zero.
      pulse_clear();
      apply(2, 3, 1'b0, 3, 16'h0003);
      apply(2, 10, 1'b1, 0, 16'h0000);

      // Round robin from ptr=0: 0,1,2,3 then 0,1 with req=0011, 18 cycles apart.
      pulse_clear();
      amount = {8'd4, 8'd3, 8'd2, 8'd1};
      sub    = 4'b0;
      req    = 4'b1111;
      exp_sc = 0;
      for (int k = 0; k < 6; k++) begin
         g = (k < 4) ? k : k - 4;
         wait_ack(cyc, a);
         check("rr_ack", 32'(a), 32'(1 << g));
         if (k > 0) check("rr_gap", cyc, 18);
         req[g] = 1'b0;
         exp_sc = exp_sc + g + 1;
         check("rr_score", 32'(score), 32'(exp_sc));
         $display("rr grant=%b gap=%0d score=%0d", a, cyc, score);
         if (k == 3) req = 4'b0011;
      end

      // Clear in the 5th conversion cycle of an update to 1234.
      pulse_clear();
      for (int k = 1; k <= 4; k++) apply(0, 255, 1'b0, 255 * k, to_bcd(255 * k));
      req[0]    = 1'b1;
      amount[0] = 8'd214;
      sub[0]    = 1'b0;
      wait_ack(cyc, a);
      req[0] = 1'b0;
      check("c_ack", 32'(a), 32'h1);
      check("c_score", 32'(score), 32'd1234);
      repeat (4) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("c_score0", 32'(score), 32'h0);
      check("c_bcd0", 32'(bcd), 32'h0);
      check("c_busy0", 32'(busy), 32'h0);
      upd = 0;
      repeat (25) begin
         @(negedge clk);
         if (bcd_update) upd++;
      end
      check("c_no_update", upd, 0);
      check("c_bcd_kept", 32'(bcd), 32'h0);
      prev_bcd = 16'h0;
      $display("clear_mid score=%0d bcd=%h updates=%0d", score, bcd, upd);

      // clear and req[3] together: clear wins, grant follows next cycle.
      apply(1, 7, 1'b0, 7, 16'h0007);
      clear     = 1'b1;
      req[3]    = 1'b1;
      amount[3] = 8'd9;
      sub[3]    = 1'b0;
      @(negedge clk);
      clear = 1'b0;
      check("p_ack0", 32'(ack), 32'h0);
      check("p_score0", 32'(score), 32'h0);
      check("p_busy0", 32'(busy), 32'h0);
      prev_bcd = 16'h0;
      @(negedge clk);
      req[3] = 1'b0;
      check("p_ack3", 32'(ack), 32'h8);
      check("p_score9", 32'(score), 32'd9);
      wait_update(lat);
      check("p_latency", lat, 17);
      check("p_bcd", 32'(bcd), 32'h0009);
      $display("clear_prio score=%0d bcd=%h", score, bcd);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
